// File: rtl/adc0809_emulator.sv
// rtl/adc0809_emulator.sv - ADC0809 8-channel converter pin-level emulator
module adc0809_emulator #(
  parameter int CONV_CLKS = 64
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        adc_clk,
  input  logic        start,
  input  logic        oe,
  input  logic        addr_a,
  input  logic        addr_b,
  input  logic        addr_c,
  input  logic [63:0] ch_values,
  output logic [7:0]  data_out,
  output logic        data_drive,
  output logic        eoc,
  output logic [2:0]  ch_latched
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] CONV_LAST = 8'(CONV_CLKS);

  // Bit 0 is the capture flop, bit 1 the synchronized level, bit 2 the
  // previous synchronized level used for edge detection.
  logic [2:0] adc_sync;
  logic [2:0] start_sync;
  logic [1:0] oe_pipe;
  logic       oe_sync;
  logic [2:0] addr_s1;
  logic [2:0] addr_s2;

  logic adc_rise_q;
  logic start_rise_q;
  logic start_fall_q;

  state_t     state, state_nxt;
  logic [7:0] count, count_nxt;
  logic [7:0] hold, hold_nxt;
  logic [7:0] result, result_nxt;
  logic       eoc_nxt;
  logic [2:0] ch_nxt;
  logic [7:0] count_inc;

  assign count_inc = count + 8'd1;

  // Bring the driver's pins into the sys_clk domain.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_sync   <= 3'b000;
      start_sync <= 3'b000;
      oe_pipe    <= 2'b00;
      oe_sync    <= 1'b0;
      addr_s1    <= 3'd0;
      addr_s2    <= 3'd0;
    end else begin
      adc_sync   <= {adc_sync[1:0], adc_clk};
      start_sync <= {start_sync[1:0], start};
      oe_pipe    <= {oe_pipe[0], oe};
      oe_sync    <= oe_pipe[1];
      addr_s1    <= {addr_c, addr_b, addr_a};
      addr_s2    <= addr_s1;
    end
  end

  // Register the detected edges so every pin sees the same input latency.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_rise_q   <= 1'b0;
      start_rise_q <= 1'b0;
      start_fall_q <= 1'b0;
    end else begin
      adc_rise_q   <= adc_sync[1] & ~adc_sync[2];
      start_rise_q <= start_sync[1] & ~start_sync[2];
      start_fall_q <= ~start_sync[1] & start_sync[2];
    end
  end

  // Conversion state and datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 8'd0;
      hold       <= 8'h00;
      result     <= 8'h00;
      eoc        <= 1'b1;
      ch_latched <= 3'd0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      hold       <= hold_nxt;
      result     <= result_nxt;
      eoc        <= eoc_nxt;
      ch_latched <= ch_nxt;
    end
  end

  // Next-state logic: a start rising edge wins from any state and discards
  // whatever conversion was in flight.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    hold_nxt   = hold;
    result_nxt = result;
    eoc_nxt    = eoc;
    ch_nxt     = ch_latched;
    if (start_rise_q) begin
      ch_nxt    = addr_s2;
      eoc_nxt   = 1'b0;
      count_nxt = 8'd0;
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (start_fall_q) begin
            hold_nxt  = ch_values[{ch_latched, 3'b000} +: 8];
            count_nxt = 8'd0;
            state_nxt = CONVERT;
          end
        end
        CONVERT: begin
          if (adc_rise_q) begin
            count_nxt = count_inc;
            if (count_inc == CONV_LAST) begin
              result_nxt = hold;
              eoc_nxt    = 1'b1;
              state_nxt  = DONE;
            end
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // Data pins: drive the last completed result only while oe is asserted.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_drive <= 1'b0;
      data_out   <= 8'h00;
    end else begin
      data_drive <= oe_sync;
      data_out   <= oe_sync ? result : 8'h00;
    end
  end

endmodule

// File: tb/tb_adc0809_emulator.sv
// tb/tb_adc0809_emulator.sv - self-checking bench for adc0809_emulator
module tb_adc0809_emulator;

  localparam int CONV = 64;

  logic        sys_clk;
  logic        rst_n;
  logic        adc_clk;
  logic        start;
  logic        oe;
  logic        addr_a, addr_b, addr_c;
  logic [63:0] ch_values;
  logic [7:0]  data_out;
  logic        data_drive;
  logic        eoc;
  logic [2:0]  ch_latched;

  int errs;
  int checks;

  adc0809_emulator #(.CONV_CLKS(CONV)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .adc_clk    (adc_clk),
    .start      (start),
    .oe         (oe),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .addr_c     (addr_c),
    .ch_values  (ch_values),
    .data_out   (data_out),
    .data_drive (data_drive),
    .eoc        (eoc),
    .ch_latched (ch_latched)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_ch(input int n, input logic [7:0] v);
    ch_values[n*8 +: 8] = v;
  endtask

  task automatic start_pulse(input logic [2:0] a, input int w);
    {addr_c, addr_b, addr_a} = a;
    cyc(1);
    start = 1'b1;
    cyc(w);
    start = 1'b0;
    cyc(5);
  endtask

  task automatic adc_pulses(input int n, input int ph);
    repeat (n) begin
      adc_clk = 1'b1;
      cyc(ph);
      adc_clk = 1'b0;
      cyc(ph);
    end
  endtask

  // The final adc_clk rising edge: eoc must rise exactly after the third
  // sys_clk edge following the first capture of the pin change.
  task automatic last_edge(input string nm);
    chk({nm, " eoc low before last edge"}, eoc, 1'b0);
    adc_clk = 1'b1;
    cyc(3);
    chk({nm, " eoc low at k+2"}, eoc, 1'b0);
    cyc(1);
    chk({nm, " eoc high at k+3"}, eoc, 1'b1);
    adc_clk = 1'b0;
    cyc(4);
  endtask

  task automatic full_conv(input logic [2:0] a, input int w, input string nm);
    start_pulse(a, w);
    adc_pulses(CONV - 1, 4);
    last_edge(nm);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [7:0] val;
    logic       oe;
    int         w;
    logic [7:0] exp_data;
    logic       exp_drive;
    logic [2:0] exp_ch;
  } vec_t;

  vec_t vecs[6];

  // Reference model: transaction-level view of the converter.
  logic [7:0] m_result;
  logic [7:0] m_hold;
  logic [2:0] m_ch;
  bit         m_busy;
  int         m_edges;
  logic       m_oe;

  task automatic model_check(input int it);
    chk($sformatf("rnd%0d eoc", it), eoc, !m_busy);
    chk($sformatf("rnd%0d ch_latched", it), ch_latched, m_ch);
    chk($sformatf("rnd%0d data_drive", it), data_drive, m_oe);
    chk($sformatf("rnd%0d data_out", it), data_out, m_oe ? m_result : 8'h00);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst_n = 1'b0;
    adc_clk = 1'b0;
    start = 1'b0;
    oe = 1'b0;
    {addr_c, addr_b, addr_a} = 3'd0;
    ch_values = 64'h0;

    vecs[0] = '{3'd1, 8'hA5, 1'b1, 2, 8'hA5, 1'b1, 3'd1};
    vecs[1] = '{3'd2, 8'h00, 1'b1, 1, 8'h00, 1'b1, 3'd2};
    vecs[2] = '{3'd4, 8'h3C, 1'b0, 3, 8'h00, 1'b0, 3'd4};
    vecs[3] = '{3'd6, 8'h80, 1'b1, 1, 8'h80, 1'b1, 3'd6};
    vecs[4] = '{3'd7, 8'h7E, 1'b0, 1, 8'h00, 1'b0, 3'd7};
    vecs[5] = '{3'd0, 8'hFF, 1'b1, 2, 8'hFF, 1'b1, 3'd0};

    cyc(3);
    chk("reset eoc", eoc, 1'b1);
    chk("reset data_out", data_out, 8'h00);
    chk("reset data_drive", data_drive, 1'b0);
    chk("reset ch_latched", ch_latched, 3'd0);
    rst_n = 1'b1;
    cyc(3);

    // Basic conversion on ch5 with oe held low, start-to-eoc latency.
    set_ch(5, 8'hD6);
    {addr_c, addr_b, addr_a} = 3'b101;
    cyc(1);
    start = 1'b1;
    cyc(3);
    chk("start latency eoc still high", eoc, 1'b1);
    cyc(1);
    chk("start latency eoc low", eoc, 1'b0);
    start = 1'b0;
    cyc(5);
    chk("ch_latched ch5", ch_latched, 3'd5);
    adc_pulses(CONV - 1, 4);
    last_edge("conv ch5");
    chk("oe low data_out", data_out, 8'h00);
    chk("oe low data_drive", data_drive, 1'b0);
    oe = 1'b1;
    cyc(3);
    chk("oe latency drive still low", data_drive, 1'b0);
    chk("oe latency data still zero", data_out, 8'h00);
    cyc(1);
    chk("oe latency drive high", data_drive, 1'b1);
    chk("oe latency data D6", data_out, 8'hD6);

    // Sample-and-hold: ch5 changes after the first adc_clk edge.
    start_pulse(3'd5, 2);
    adc_pulses(1, 4);
    set_ch(5, 8'h10);
    adc_pulses(CONV - 2, 4);
    last_edge("s&h conv");
    chk("s&h keeps old value", data_out, 8'hD6);
    start_pulse(3'd5, 2);
    adc_pulses(10, 4);
    chk("oe during convert shows previous", data_out, 8'hD6);
    adc_pulses(CONV - 11, 4);
    last_edge("s&h next conv");
    chk("next conversion new value", data_out, 8'h10);

    // Abort: new start at adc_clk edge 30 selecting ch0.
    set_ch(0, 8'h55);
    start_pulse(3'd5, 2);
    adc_pulses(29, 4);
    {addr_c, addr_b, addr_a} = 3'b000;
    adc_clk = 1'b1;
    start = 1'b1;
    cyc(4);
    adc_clk = 1'b0;
    start = 1'b0;
    cyc(5);
    chk("abort eoc low", eoc, 1'b0);
    chk("abort ch_latched", ch_latched, 3'd0);
    adc_pulses(CONV - 1, 4);
    chk("abort result untouched", data_out, 8'h10);
    last_edge("abort reconv");
    chk("abort reconv data", data_out, 8'h55);

    // adc_clk stalls at edge 40 for 1000 sys_clk cycles.
    set_ch(3, 8'h3C);
    start_pulse(3'd3, 1);
    adc_pulses(40, 4);
    cyc(1000);
    chk("stall eoc low", eoc, 1'b0);
    adc_pulses(23, 4);
    last_edge("stall resume");
    chk("stall data", data_out, 8'h3C);

    // Reset mid-conversion, then a full conversion on ch7.
    set_ch(7, 8'hFF);
    start_pulse(3'd7, 2);
    adc_pulses(20, 4);
    rst_n = 1'b0;
    #1;
    chk("midreset eoc", eoc, 1'b1);
    chk("midreset data_out", data_out, 8'h00);
    chk("midreset data_drive", data_drive, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("post reset data_out", data_out, 8'h00);
    full_conv(3'd7, 2, "post reset conv");
    chk("post reset data FF", data_out, 8'hFF);

    // Table-driven conversions.
    for (int i = 0; i < 6; i++) begin
      set_ch(vecs[i].addr, vecs[i].val);
      oe = vecs[i].oe;
      full_conv(vecs[i].addr, vecs[i].w, $sformatf("vec%0d", i));
      cyc(2);
      chk($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_data);
      chk($sformatf("vec%0d data_drive", i), data_drive, vecs[i].exp_drive);
      chk($sformatf("vec%0d ch_latched", i), ch_latched, vecs[i].exp_ch);
    end

    // Randomized operations against the reference model.
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    m_result = 8'h00;
    m_hold = 8'h00;
    m_ch = 3'd0;
    m_busy = 0;
    m_edges = 0;
    m_oe = oe;
    cyc(5);
    model_check(-1);
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          logic [2:0] a;
          a = 3'($urandom_range(0, 7));
          start_pulse(a, $urandom_range(1, 3));
          m_ch = a;
          m_busy = 1;
          m_edges = 0;
          m_hold = ch_values[a*8 +: 8];
        end
        2, 3: begin
          int n;
          int ph;
          n = (it % 3 == 0) ? CONV : $urandom_range(1, 70);
          ph = $urandom_range(2, 4);
          adc_pulses(n, ph);
          cyc(4);
          for (int e = 0; e < n; e++) begin
            if (m_busy) begin
              m_edges++;
              if (m_edges == CONV) begin
                m_result = m_hold;
                m_busy = 0;
              end
            end
          end
        end
        4: begin
          oe = ~oe;
          m_oe = oe;
          cyc(5);
        end
        default: begin
          ch_values = {$urandom, $urandom};
          cyc($urandom_range(1, 6));
        end
      endcase
      model_check(it);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
